// File: rtl/rr_pkt_mux_pkg.sv
// rr_pkt_mux_pkg: shared state encoding and watchdog sizing for the packet mux
package rr_pkt_mux_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam int TIMEOUT_CNT_MAX_DFLT = 32;
  localparam int TIMEOUT_W = $clog2(TIMEOUT_CNT_MAX_DFLT + 1);
  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction
endpackage

// File: rtl/rr_pkt_mux_pick.sv
// rr_pick: cyclic first-set-bit picker starting at one-hot base (doubled-vector subtract)
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] base,
  output logic [N-1:0] win
);
  logic [2*N-1:0] d, g;
  assign d = {req, req};
  // subtracting base clears the lowest request at or above base, wrapping via the upper copy
  assign g = d & ~(d - {{N{1'b0}}, base});
  assign win = g[N-1:0] | g[2*N-1:N];
endmodule

// File: rtl/rr_pkt_mux.sv
// rr_pkt_mux: packet-granular round-robin link mux with mid-packet stall watchdog
module rr_pkt_mux
  import rr_pkt_mux_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW = 16,
  parameter int TIMEOUT_CNT_MAX = TIMEOUT_CNT_MAX_DFLT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ*DW-1:0]   s_tdata,
  input  logic [NREQ-1:0]      s_tvalid,
  input  logic [NREQ-1:0]      s_tlast,
  output logic [NREQ-1:0]      s_tready,
  output logic [DW-1:0]        m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  output logic                 m_tuser,
  input  logic                 m_tready,
  output logic [NREQ-1:0]      grant,
  output logic                 timeoutStrobe,
  output logic [15:0]          timeoutCount
);
  localparam int TW = cnt_w(TIMEOUT_CNT_MAX);
  logic [1:0] state;
  logic [NREQ-1:0] base, win;
  logic [TW-1:0] wd;
  logic [DW-1:0] gdata;
  logic gvalid, glast, xfer, flush, expire, done;
  rr_pick #(.N(NREQ)) u_pick (.req(s_tvalid), .base(base), .win(win));
  always_comb begin
    gdata = '0;
    for (int i = 0; i < NREQ; i++) gdata = gdata | (grant[i] ? s_tdata[i*DW +: DW] : '0);
  end
  assign gvalid = |(grant & s_tvalid);
  assign glast = |(grant & s_tlast);
  assign xfer = state == ST_XFER;
  assign flush = state == ST_FLUSH;
  assign expire = xfer & ~gvalid & (wd == TW'(TIMEOUT_CNT_MAX - 1));
  assign done = (xfer & gvalid & glast & m_tready) | (flush & m_tready);
  assign m_tvalid = xfer ? gvalid : flush;
  assign m_tlast = xfer ? glast : flush;
  assign m_tuser = flush;
  assign m_tdata = xfer ? gdata : '0;
  assign s_tready = xfer ? grant & {NREQ{m_tready}} : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      grant <= '0;
      base <= {{(NREQ-1){1'b0}}, 1'b1};
      wd <= '0;
      timeoutStrobe <= 1'b0;
      timeoutCount <= '0;
    end else begin
      timeoutStrobe <= expire;
      if (expire) timeoutCount <= timeoutCount + {15'd0, timeoutCount != 16'hFFFF};
      // only a granted-source valid gap counts; backpressure leaves wd at zero
      wd <= (xfer & ~gvalid) ? wd + 1'b1 : '0;
      if (state == ST_IDLE && |s_tvalid) begin
        grant <= win;
        state <= ST_XFER;
      end else if (done) begin
        base <= {grant[NREQ-2:0], grant[NREQ-1]};
        grant <= '0;
        state <= ST_IDLE;
      end else if (expire) state <= ST_FLUSH;
    end
endmodule
